// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the pipeline writeback has priority, and
// long-latency aux results wait in a 2-entry FIFO with a starvation override.
module wb_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ZERO_REG     = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_reg,
  input  logic [63:0] pipe_data,
  input  logic        aux_valid,
  input  logic [4:0]  aux_reg,
  input  logic [63:0] aux_data,
  output logic        aux_ready,
  output logic        stall_pipe,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [63:0] rf_wdata
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
  localparam logic [4:0]       ZREG  = 5'(ZERO_REG);

  typedef enum logic {ST_PIPE, ST_FORCE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       count_q, count_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [4:0]       fifo_reg_q [2];
  logic [4:0]       fifo_reg_d [2];
  logic [63:0]      fifo_data_q [2];
  logic [63:0]      fifo_data_d [2];
  logic [CNT_W-1:0] starve_q, starve_d;
  logic [CNT_W-1:0] starve_inc;
  logic             rf_we_q, rf_we_d;
  logic [4:0]       rf_waddr_q, rf_waddr_d;
  logic [63:0]      rf_wdata_q, rf_wdata_d;

  logic        pipe_req;
  logic        fifo_ne;
  logic        push;
  logic        pop;
  logic        take_pipe;
  logic [4:0]  head_reg;
  logic [63:0] head_data;

  // aux_ready comes from the registered count only, so a full FIFO never
  // accepts in the same cycle it pops.
  assign aux_ready  = (count_q < 2'd2);
  assign stall_pipe = (state_q == ST_FORCE);
  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;

  assign pipe_req   = pipe_we && (pipe_reg != ZREG);
  assign fifo_ne    = (count_q != 2'd0);
  assign push       = aux_valid && aux_ready;
  assign head_reg   = fifo_reg_q[rd_ptr_q];
  assign head_data  = fifo_data_q[rd_ptr_q];
  assign starve_inc = (starve_q == LIMIT) ? starve_q : starve_q + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_PIPE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_PIPE:  if (pipe_req && fifo_ne && (starve_inc == LIMIT)) state_d = ST_FORCE;
      ST_FORCE: state_d = ST_PIPE;
      default:  state_d = ST_PIPE;
    endcase
  end

  always_comb begin
    take_pipe = 1'b0;
    pop       = 1'b0;
    starve_d  = '0;
    case (state_q)
      ST_PIPE: begin
        if (pipe_req) begin
          take_pipe = 1'b1;
          starve_d  = fifo_ne ? starve_inc : '0;
        end else begin
          pop = fifo_ne;
        end
      end
      ST_FORCE: pop = fifo_ne;
      default: ;
    endcase

    // A granted zero-register entry still consumes its slot but writes nothing.
    rf_we_d    = take_pipe || (pop && (head_reg != ZREG));
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (take_pipe) begin
      rf_waddr_d = pipe_reg;
      rf_wdata_d = pipe_data;
    end else if (rf_we_d) begin
      rf_waddr_d = head_reg;
      rf_wdata_d = head_data;
    end

    count_d  = count_q + {1'b0, push} - {1'b0, pop};
    rd_ptr_d = rd_ptr_q ^ pop;
    wr_ptr_d = wr_ptr_q ^ push;
    fifo_reg_d  = fifo_reg_q;
    fifo_data_d = fifo_data_q;
    if (push) begin
      fifo_reg_d[wr_ptr_q]  = aux_reg;
      fifo_data_d[wr_ptr_q] = aux_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= 64'd0;
    end else begin
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  // FIFO payload needs no reset: count and pointers decide what is live.
  always_ff @(posedge clk) begin
    fifo_reg_q  <= fifo_reg_d;
    fifo_data_q <= fifo_data_d;
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios plus a randomized run against
// a queue-based reference model.
module tb_wb_port_arbiter;

  localparam int LIMIT = 4;
  localparam int ZR    = 31;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_reg;
  logic [63:0] pipe_data;
  logic        aux_valid;
  logic [4:0]  aux_reg;
  logic [63:0] aux_data;
  logic        aux_ready;
  logic        stall_pipe;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;

  int errors = 0;
  int checks = 0;

  wb_port_arbiter #(.STARVE_LIMIT(LIMIT), .ZERO_REG(ZR)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_reg(pipe_reg), .pipe_data(pipe_data),
    .aux_valid(aux_valid), .aux_reg(aux_reg), .aux_data(aux_data),
    .aux_ready(aux_ready), .stall_pipe(stall_pipe),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_we = 1'b0; pipe_reg = 5'd0; pipe_data = 64'd0;
    aux_valid = 1'b0; aux_reg = 5'd0; aux_data = 64'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we: got %0b expected 0", rf_we); end
    checks++; if (rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_rf_waddr: got %0d expected 0", rf_waddr); end
    checks++; if (rf_wdata !== 64'd0) begin errors++; $display("FAIL reset_rf_wdata: got %0h expected 0", rf_wdata); end
    checks++; if (stall_pipe !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b expected 0", stall_pipe); end
    checks++; if (aux_ready !== 1'b1) begin errors++; $display("FAIL reset_aux_ready: got %0b expected 1", aux_ready); end
  endtask

  task automatic test_pipe_only();
    do_reset();
    pipe_we = 1'b1; pipe_reg = 5'd5; pipe_data = 64'hDEAD;
    tick();
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL pipe_we: got %0b expected 1", rf_we); end
    checks++; if (rf_waddr !== 5'd5) begin errors++; $display("FAIL pipe_waddr: got %0d expected 5", rf_waddr); end
    checks++; if (rf_wdata !== 64'hDEAD) begin errors++; $display("FAIL pipe_wdata: got %0h expected dead", rf_wdata); end
    pipe_reg = 5'd31; pipe_data = 64'hBEEF;
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL pipe_zero_reg: got %0b expected 0", rf_we); end
    idle_inputs();
  endtask

  task automatic test_aux_idle();
    do_reset();
    aux_valid = 1'b1; aux_reg = 5'd7; aux_data = 64'h1234;
    tick();
    aux_valid = 1'b0;
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL aux_push_cycle_we: got %0b expected 0", rf_we); end
    tick();
    checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL aux_pop_we: got %0b expected 1", rf_we); end
    checks++; if (rf_waddr !== 5'd7) begin errors++; $display("FAIL aux_pop_waddr: got %0d expected 7", rf_waddr); end
    checks++; if (rf_wdata !== 64'h1234) begin errors++; $display("FAIL aux_pop_wdata: got %0h expected 1234", rf_wdata); end
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL aux_after_pop_we: got %0b expected 0", rf_we); end
  endtask

  task automatic test_full_fifo();
    do_reset();
    pipe_we = 1'b1; pipe_reg = 5'd3; pipe_data = 64'h33;
    aux_valid = 1'b1; aux_reg = 5'd10; aux_data = 64'hA;
    tick();
    aux_reg = 5'd11; aux_data = 64'hB;
    tick();
    checks++; if (aux_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0b expected 0", aux_ready); end
    aux_reg = 5'd12; aux_data = 64'hC;
    tick();
    checks++; if (aux_ready !== 1'b0) begin errors++; $display("FAIL full_ready_hold: got %0b expected 0", aux_ready); end
    idle_inputs();
    tick();
    checks++; if (rf_waddr !== 5'd10 || rf_wdata !== 64'hA || rf_we !== 1'b1) begin errors++; $display("FAIL full_pop1: got we=%0b reg=%0d data=%0h expected we=1 reg=10 data=a", rf_we, rf_waddr, rf_wdata); end
    tick();
    checks++; if (rf_waddr !== 5'd11 || rf_wdata !== 64'hB || rf_we !== 1'b1) begin errors++; $display("FAIL full_pop2: got we=%0b reg=%0d data=%0h expected we=1 reg=11 data=b", rf_we, rf_waddr, rf_wdata); end
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL full_third_dropped: got we=%0b expected 0", rf_we); end
    checks++; if (aux_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after: got %0b expected 1", aux_ready); end
  endtask

  task automatic test_starvation();
    do_reset();
    pipe_we = 1'b1; pipe_reg = 5'd4; pipe_data = 64'h0;
    aux_valid = 1'b1; aux_reg = 5'd9; aux_data = 64'h99;
    tick();
    aux_valid = 1'b0;
    for (int k = 1; k <= LIMIT; k++) begin
      pipe_data = 64'(k);
      tick();
      checks++; if (stall_pipe !== (k == LIMIT)) begin errors++; $display("FAIL starve_stall_%0d: got %0b expected %0b", k, stall_pipe, (k == LIMIT)); end
      checks++; if (rf_waddr !== 5'd4 || rf_wdata !== 64'(k)) begin errors++; $display("FAIL starve_win_%0d: got reg=%0d data=%0h expected reg=4 data=%0h", k, rf_waddr, rf_wdata, k); end
    end
    pipe_reg = 5'd20; pipe_data = 64'hBAD;
    tick();
    checks++; if (stall_pipe !== 1'b0) begin errors++; $display("FAIL force_one_cycle: got %0b expected 0", stall_pipe); end
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 64'h99) begin errors++; $display("FAIL force_write: got we=%0b reg=%0d data=%0h expected we=1 reg=9 data=99", rf_we, rf_waddr, rf_wdata); end
    pipe_data = 64'h600D;
    tick();
    checks++; if (rf_waddr !== 5'd20 || rf_wdata !== 64'h600D) begin errors++; $display("FAIL force_resume: got reg=%0d data=%0h expected reg=20 data=600d", rf_waddr, rf_wdata); end
    idle_inputs();
  endtask

  task automatic test_simultaneous();
    do_reset();
    pipe_we = 1'b1; pipe_reg = 5'd2; pipe_data = 64'h2;
    aux_valid = 1'b1; aux_reg = 5'd13; aux_data = 64'h13;
    tick();
    pipe_we = 1'b0; aux_reg = 5'd14; aux_data = 64'h14;
    tick();
    aux_valid = 1'b0;
    checks++; if (rf_waddr !== 5'd13 || rf_wdata !== 64'h13) begin errors++; $display("FAIL simul_older: got reg=%0d data=%0h expected reg=13 data=13", rf_waddr, rf_wdata); end
    checks++; if (aux_ready !== 1'b1) begin errors++; $display("FAIL simul_ready: got %0b expected 1", aux_ready); end
    tick();
    checks++; if (rf_waddr !== 5'd14 || rf_wdata !== 64'h14) begin errors++; $display("FAIL simul_newer: got reg=%0d data=%0h expected reg=14 data=14", rf_waddr, rf_wdata); end
    tick();
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL simul_count1: got we=%0b expected 0", rf_we); end
  endtask

  task automatic test_reset_in_force();
    int n;
    do_reset();
    pipe_we = 1'b1; pipe_reg = 5'd1; pipe_data = 64'h1;
    aux_valid = 1'b1; aux_reg = 5'd21; aux_data = 64'h21;
    tick();
    aux_reg = 5'd22; aux_data = 64'h22;
    tick();
    aux_valid = 1'b0;
    n = 0;
    while (stall_pipe !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checks++; if (stall_pipe !== 1'b1) begin errors++; $display("FAIL rif_reach_force: got %0b expected 1 within bound", stall_pipe); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pipe_we = 1'b0;
    checks++; if (stall_pipe !== 1'b0 || rf_we !== 1'b0 || aux_ready !== 1'b1) begin errors++; $display("FAIL rif_after_reset: got stall=%0b we=%0b ready=%0b expected 0 0 1", stall_pipe, rf_we, aux_ready); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rif_stale_%0d: got we=%0b reg=%0d expected we=0", k, rf_we, rf_waddr); end
    end
  endtask

  typedef struct {
    logic [4:0]  r;
    logic [63:0] d;
  } ent_t;

  task automatic test_random();
    ent_t        q[$];
    ent_t        h;
    int          starve;
    bit          force_slot;
    logic        m_we;
    logic [4:0]  m_addr;
    logic [63:0] m_data;
    bit          accept;
    int          pipe_pct;
    do_reset();
    q.delete();
    starve = 0; force_slot = 0; m_we = 0; m_addr = 0; m_data = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      pipe_pct  = ((cyc / 300) % 2 == 0) ? 90 : 40;
      rst       = ($urandom_range(0, 199) == 0);
      pipe_we   = ($urandom_range(0, 99) < pipe_pct);
      pipe_reg  = ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 30));
      pipe_data = {$urandom, $urandom};
      aux_valid = ($urandom_range(0, 99) < 50);
      aux_reg   = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 30));
      aux_data  = {$urandom, $urandom};
      #1;
      checks++; if (aux_ready !== (q.size() < 2)) begin errors++; $display("FAIL rnd_ready@%0d: got %0b expected %0b", cyc, aux_ready, (q.size() < 2)); end
      checks++; if (stall_pipe !== force_slot) begin errors++; $display("FAIL rnd_stall@%0d: got %0b expected %0b", cyc, stall_pipe, force_slot); end
      if (rst) begin
        q.delete();
        starve = 0; force_slot = 0; m_we = 0; m_addr = 0; m_data = 0;
      end else begin
        accept = aux_valid && (q.size() < 2);
        m_we = 0;
        if (force_slot || !(pipe_we && pipe_reg != 5'd31)) begin
          if (q.size() > 0) begin
            h = q.pop_front();
            if (h.r != 5'd31) begin m_we = 1; m_addr = h.r; m_data = h.d; end
          end
          starve = 0;
          force_slot = 0;
        end else begin
          m_we = 1; m_addr = pipe_reg; m_data = pipe_data;
          if (q.size() > 0) begin
            starve = (starve + 1 > LIMIT) ? LIMIT : starve + 1;
            force_slot = (starve == LIMIT);
          end else begin
            starve = 0;
          end
        end
        if (accept) q.push_back('{r: aux_reg, d: aux_data});
      end
      @(posedge clk);
      #1;
      checks++; if (rf_we !== m_we) begin errors++; $display("FAIL rnd_we@%0d: got %0b expected %0b", cyc, rf_we, m_we); end
      checks++; if (rf_waddr !== m_addr || rf_wdata !== m_data) begin errors++; $display("FAIL rnd_wr@%0d: got reg=%0d data=%0h expected reg=%0d data=%0h", cyc, rf_waddr, rf_wdata, m_addr, m_data); end
      #1;
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_pipe_only();
    test_aux_idle();
    test_full_fifo();
    test_starvation();
    test_simultaneous();
    test_reset_in_force();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive cycles an aux entry may wait before forced grant.
REQ-002 SHALL have parameter ZERO_REG, default 31: hardwired-zero register index; writes to it are suppressed.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1: synchronous, active-high reset.
REQ-005 SHALL have port pipe_we  input  1: pipeline writeback request (RegWrite from the writeback stage).
REQ-006 SHALL have port pipe_reg  input  5: pipeline destination register.
REQ-007 SHALL have port pipe_data  input  64: pipeline write data (already MemToReg-selected).
REQ-008 SHALL have port aux_valid  input  1: long-latency unit (mul/div) result valid.
REQ-009 SHALL have port aux_reg  input  5: aux destination register.
REQ-010 SHALL have port aux_data  input  64: aux result data.
REQ-011 SHALL have port aux_ready  output  1: aux FIFO can accept this cycle.
REQ-012 SHALL have port stall_pipe  output  1: pipeline must hold writeback inputs this cycle.
REQ-013 SHALL have port rf_we  output  1: register-file write enable, registered.
REQ-014 SHALL have port rf_waddr  output  5: register-file write address, registered.
REQ-015 SHALL have port rf_wdata  output  64: register-file write data, registered.

Function
REQ-016 SHALL buffer aux results in a 2-entry FIFO (reg+data); push when aux_valid && aux_ready.
REQ-017 SHALL drive aux_ready = (FIFO count < 2), decoded from registered count only; no same-cycle bypass when full, even if a pop occurs.
REQ-018 SHALL treat pipe_we with pipe_reg == ZERO_REG as no pipeline request.
REQ-019 SHALL use a two-state FSM: PIPE (pipeline priority) and FORCE (aux grant).
REQ-020 In PIPE: valid pipeline request -> rf_* load pipe_reg/pipe_data next edge; else if FIFO non-empty -> pop head into rf_*; else rf_we <= 0.
REQ-021 SHALL keep a starve counter: in PIPE, increments when FIFO non-empty and pipeline wins; clears on any pop or when FIFO empty; saturates at STARVE_LIMIT.
REQ-022 SHALL transition PIPE -> FORCE on the edge where counter reaches STARVE_LIMIT; stall_pipe = (state == FORCE).
REQ-023 In FORCE: pipeline inputs ignored; FIFO head popped into rf_*; counter cleared; return to PIPE next edge (FORCE lasts exactly one cycle).
REQ-024 Aux entry with reg == ZERO_REG SHALL be popped when granted with rf_we <= 0 (slot consumed).
REQ-025 Write latency SHALL be exactly 1 cycle from grant to rf_we visible.
REQ-026 Push and pop in the same cycle SHALL leave count unchanged and preserve FIFO order.
REQ-027 SHALL perform no register-address ordering checks between pipeline and aux; WAW ordering is owned by the issue scoreboard.

Reset
REQ-028 On rst: state PIPE, FIFO empty (entries discarded), counter 0, rf_we 0, rf_waddr 0, rf_wdata 0, stall_pipe 0; aux_ready 1 in the first cycle after reset.
REQ-029 rst SHALL override all concurrent pushes, pops and grants in that cycle, including mid-FORCE.

Verification
REQ-030 Pipe-only: pipe_we=1, reg=5, data=0xDEAD -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEAD; reg=31 -> rf_we=0.
REQ-031 Aux idle slot: pipe_we=0, aux push reg=7 data=0x1234 -> pops next cycle; rf_we=1, rf_waddr=7 one cycle after pop.
REQ-032 Full FIFO: push 2 entries while pipe_we held 1 -> aux_ready=0; third aux_valid not accepted; count stays 2.
REQ-033 Starvation: FIFO non-empty, pipe_we=1 continuously -> after 4 pipeline wins stall_pipe=1 for exactly 1 cycle; head written, pipe data that cycle dropped.
REQ-034 Simultaneous: count=1, pop and push same cycle -> count stays 1, popped entry is the older.
REQ-035 Reset in FORCE with 2 entries -> next cycle stall_pipe=0, rf_we=0, aux_ready=1, no stale writes afterward.
